// File: rtl/branch_pkg.sv
// Shared types and constants for the EX-stage branch resolution unit
// and its predictor-update queue.
package branch_pkg;

    localparam int BP_XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE,
        FLUSH
    } bru_state_t;

    typedef struct packed {
        logic [BP_XLEN-1:0] pc;
        logic               taken;
        logic               mispred;
    } bp_update_t;

    // 010/011 are not conditional-branch encodings.
    function automatic logic f3_legal(input logic [2:0] f3);
        return f3[2:1] != 2'b01;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO holding resolved branch outcomes until the predictor
// accepts them; a push into a full FIFO is allowed when a pop happens too.
module bp_update_fifo
    import branch_pkg::*;
#(
    parameter int UPD_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  bp_update_t wdata,
    output bp_update_t rdata,
    output logic       empty,
    output logic       full
);

    localparam int PW = $clog2(UPD_DEPTH);
    localparam int CW = $clog2(UPD_DEPTH + 1);

    bp_update_t        mem_q [UPD_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(UPD_DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; only pointers and count define validity,
    // so clearing the array would just cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/branch_resolution_unit.sv
// Resolves EX-stage conditional branches, redirects fetch and flushes on a
// mispredict, and queues outcomes for the YAGS predictor update port.
module branch_resolution_unit
    import branch_pkg::*;
#(
    parameter int XLEN         = BP_XLEN,
    parameter int UPD_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic            br_un,
    input  logic            br_lt,
    input  logic            br_eq,
    output logic            stall_ex,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            upd_valid,
    input  logic            upd_ready,
    output logic [XLEN-1:0] upd_pc,
    output logic            upd_taken,
    output logic            upd_mispred,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispred
);

    localparam int FCW = $clog2(FLUSH_CYCLES + 1);

    bru_state_t      state_q, state_d;
    logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [31:0]     perf_branches_q, perf_branches_d;
    logic [31:0]     perf_mispred_q, perf_mispred_d;

    logic       taken;
    logic       mispred;
    logic       accept;
    logic       fifo_empty;
    logic       fifo_full;
    bp_update_t fifo_wdata;
    bp_update_t fifo_rdata;

    assign br_un = ex_funct3[1];

    always_comb begin
        case (ex_funct3)
            F3_BEQ:           taken = br_eq;
            F3_BNE:           taken = ~br_eq;
            F3_BLT, F3_BLTU:  taken = br_lt;
            F3_BGE, F3_BGEU:  taken = ~br_lt;
            default:          taken = 1'b0;
        endcase
    end

    assign mispred  = taken ^ ex_pred_taken;
    assign stall_ex = ex_valid & ex_is_branch & (state_q == IDLE) & fifo_full & ~upd_ready;
    assign accept   = ex_valid & ex_is_branch & f3_legal(ex_funct3)
                    & (state_q == IDLE) & ~stall_ex;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        perf_branches_d  = perf_branches_q;
        perf_mispred_d   = perf_mispred_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    perf_branches_d = perf_branches_q + 32'd1;
                    perf_mispred_d  = perf_mispred_q + 32'(mispred);
                    if (mispred) begin
                        state_d          = FLUSH;
                        flush_cnt_d      = FCW'(FLUSH_CYCLES);
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = taken ? ex_target : ex_pc + XLEN'(4);
                    end
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q - FCW'(1);
                if (flush_cnt_q == FCW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            flush_cnt_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            perf_branches_q  <= '0;
            perf_mispred_q   <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            perf_branches_q  <= perf_branches_d;
            perf_mispred_q   <= perf_mispred_d;
        end
    end

    assign fifo_wdata = '{pc: ex_pc, taken: taken, mispred: mispred};

    bp_update_fifo #(
        .UPD_DEPTH(UPD_DEPTH)
    ) u_upd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (upd_valid & upd_ready),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign flush          = (state_q == FLUSH);
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign upd_valid      = ~fifo_empty;
    assign upd_pc         = fifo_rdata.pc;
    assign upd_taken      = fifo_rdata.taken;
    assign upd_mispred    = fifo_rdata.mispred;
    assign perf_branches  = perf_branches_q;
    assign perf_mispred   = perf_mispred_q;

endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
- Sequences the EX-stage branch comparator in the RV32I pipeline.
- Selects the comparator's signed/unsigned mode from funct3, resolves taken/not-taken, checks the result against the YAGS prediction, and drives the redirect and flush on a mispredict.
- Queues resolved outcomes in a small FIFO and drains them to the predictor update port through a valid/ready handshake.
- Sits between the EX stage, the branch comparator, the fetch redirect mux and the YAGS predictor.

Parameters:
- XLEN, 32, datapath and PC width.
- UPD_DEPTH, 4, predictor-update FIFO entries; power of two, ≥2.
- FLUSH_CYCLES, 2, number of cycles flush is held after a mispredict; ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ex_valid  in  1  EX stage holds a valid instruction
- ex_is_branch  in  1  instruction is a conditional branch
- ex_funct3  in  3  branch funct3
- ex_pc  in  XLEN  branch PC
- ex_target  in  XLEN  computed branch target
- ex_pred_taken  in  1  YAGS prediction carried down the pipe
- br_un  out  1  comparator unsigned select
- br_lt  in  1  comparator less-than
- br_eq  in  1  comparator equal
- stall_ex  out  1  hold EX; branch not accepted this cycle
- redirect_valid  out  1  fetch redirect pulse
- redirect_pc  out  XLEN  corrected fetch PC
- flush  out  1  squash IF/ID/EX
- upd_valid  out  1  predictor update available
- upd_ready  in  1  predictor accepts update
- upd_pc  out  XLEN  update PC
- upd_taken  out  1  actual outcome
- upd_mispred  out  1  prediction was wrong
- perf_branches  out  32  resolved-branch count
- perf_mispred  out  32  mispredict count

Behaviour:
- Clocking and reset: single clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: FSM is IDLE; FIFO is empty; redirect_valid, redirect_pc, flush, upd_valid and the perf counters are all 0.
- br_un is combinational and equals ex_funct3[1].
- Outcome decode (combinational):
  - 000 → taken = br_eq
  - 001 → taken = !br_eq
  - 100/110 → taken = br_lt
  - 101/111 → taken = !br_lt
  - 010/011 are illegal: no resolve, no enqueue, no redirect, no count.
- Accept condition: ex_valid & ex_is_branch & legal funct3 & state==IDLE & !stall_ex.
- stall_ex = ex_valid & ex_is_branch & state==IDLE & fifo_full & !upd_ready. A full FIFO with a simultaneous pop accepts the branch: push and pop happen in the same cycle and the count is unchanged.
- On an accepted branch at edge N:
  - Push {ex_pc, taken, mispred} into the FIFO.
  - perf_branches += 1; perf_mispred += mispred. Both wrap modulo 2^32.
- If mispred at edge N:
  - Cycle N+1: redirect_valid=1 for exactly one cycle.
  - redirect_pc = taken ? ex_target : ex_pc+4, with wrap-around addition.
  - FSM goes IDLE→FLUSH; flush=1 for FLUSH_CYCLES cycles starting at N+1, timed by a down-counter; then FSM returns to IDLE.
- In FLUSH, EX inputs are ignored: nothing is accepted, counted or stalled (stall_ex=0).
- A correct prediction causes no redirect and no flush.
- Update port: upd_valid = !empty. upd_pc, upd_taken and upd_mispred show the head entry. Pop on upd_valid & upd_ready. Data is stable while valid & !ready.
- FIFO pointers wrap at UPD_DEPTH. Empty/full are derived from a count of width $clog2(UPD_DEPTH+1).
- rst asserted mid-FLUSH or with FIFO occupied: at the next edge all state returns to reset values and queued updates are discarded.

Decomposition:
- Package branch_pkg holds:
  - funct3 localparams (F3_BEQ … F3_BGEU);
  - typedef enum {IDLE, FLUSH} bru_state_t;
  - typedef struct packed {pc, taken, mispred} bp_update_t.
- One sub-module: bp_update_fifo (synchronous FIFO of bp_update_t, parameter UPD_DEPTH). The FSM, decode and counters stay in the top module.

Test Plan:
- BEQ with data equal (br_eq=1), pred_taken=1, pc=0x100 → no redirect/flush; one update entry {0x100,1,0}; perf_branches=1.
- BLTU with br_lt=1, pred_taken=0, target=0x200 → br_un=1; redirect_valid pulses at N+1 with redirect_pc=0x200; flush high 2 cycles; a branch presented during the flush is ignored; perf_mispred=1.
- BGE with br_lt=1, pred_taken=1, pc=0xFFFF_FFFC → redirect_pc=0x0000_0000 (wrap).
- upd_ready=0; 4 correctly predicted branches fill the FIFO; 5th branch → stall_ex=1 and no counter change. Raise upd_ready in the same cycle → stall_ex=0, push+pop, count stays 4. Drain order is FIFO.
- funct3=010 with ex_valid → no enqueue, no redirect, counters unchanged.
- rst during the second flush cycle with 3 queued entries → next cycle flush=0, upd_valid=0, perf counters=0, FSM IDLE.
